mat_mult_seq: RTL and testbench

//  Sequential, fully parametrised signed matrix multiplier: OUT[M][N] = A[M][K] x B[K][N].

---
 rtl/mat_mult_seq.sv | 172 +++++++++++++++++
 tb/tb_mat_mult_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_seq.sv
// Sequential signed matrix multiplier OUT[M][N] = A[M][K] x B[K][N], one MAC lane per output row.
// Optional output saturation to OUT_W bits is enabled with the MAT_MULT_SAT_EN macro.
module mat_mult_seq #(
  parameter int M      = 2,
  parameter int K      = 2,
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(K+1),
  parameter int OUT_W  = DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] mat_a   [M][K],
  input  logic signed [DATA_W-1:0] mat_b   [K][N],
  output logic                     busy,
  output logic                     done,
  output logic signed [ACC_W-1:0]  mat_out [M][N],
  output logic                     overflow
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2*DATA_W;
  localparam logic [KW-1:0] K_LAST = KW'(K-1);
  localparam logic [JW-1:0] J_LAST = JW'(N-1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [JW-1:0]            j_q, j_d;
  logic                     done_q;
  logic signed [DATA_W-1:0] a_q       [M][K];
  logic signed [DATA_W-1:0] b_q       [K][N];
  logic signed [ACC_W-1:0]  acc_q     [M];
  logic signed [ACC_W-1:0]  res_q     [M][N];
  logic signed [ACC_W-1:0]  mat_out_q [M][N];
  logic signed [PW-1:0]     prod      [M];
  logic signed [ACC_W-1:0]  sum       [M];
  logic signed [ACC_W-1:0]  wr_val    [M];

`ifdef MAT_MULT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  function automatic logic sat_clips(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  logic clip_any;
  logic ovf_job_q;
  logic overflow_q;
`endif

  // Lane arithmetic: full-width product, sign-extended into the accumulator
  always_comb begin
    for (int i = 0; i < M; i++) begin
      prod[i] = PW'(a_q[i][k_q]) * PW'(b_q[k_q][j_q]);
      sum[i]  = (k_q == '0) ? ACC_W'(prod[i]) : acc_q[i] + ACC_W'(prod[i]);
`ifdef MAT_MULT_SAT_EN
      wr_val[i] = sat_clamp(sum[i]);
`else
      wr_val[i] = sum[i];
`endif
    end
  end

`ifdef MAT_MULT_SAT_EN
  always_comb begin
    clip_any = 1'b0;
    for (int i = 0; i < M; i++) begin
      clip_any = clip_any | sat_clips(sum[i]);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          k_d     = '0;
          j_d     = '0;
        end
      end
      CALC: begin
        if (k_q == K_LAST) begin
          k_d = '0;
          if (j_q == J_LAST) state_d = DONE;
          else               j_d     = j_q + 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture: only meaningful after an accepted start, so no reset needed
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start && !reset) begin
      a_q <= mat_a;
      b_q <= mat_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < M; i++) begin
        acc_q[i] <= '0;
        for (int j = 0; j < N; j++) begin
          res_q[i][j]     <= '0;
          mat_out_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      done_q  <= (state_q == DONE);
      if (state_q == CALC) begin
        for (int i = 0; i < M; i++) begin
          acc_q[i] <= sum[i];
          if (k_q == K_LAST) res_q[i][j_q] <= wr_val[i];
        end
      end
      if (state_q == DONE) mat_out_q <= res_q;
    end
  end

`ifdef MAT_MULT_SAT_EN
  // Job-level sticky clip flag, published to overflow together with mat_out
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_job_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      ovf_job_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state_q == CALC && k_q == K_LAST && clip_any) begin
      ovf_job_q <= 1'b1;
    end else if (state_q == DONE) begin
      overflow_q <= ovf_job_q;
    end
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy    = (state_q == CALC);
  assign done    = done_q;
  assign mat_out = mat_out_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed bench for mat_mult_seq: four shapes/width configurations sharing one clock and reset.
module tb_mat_mult_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u0: 2x2x2, DATA_W=16
  logic               start0;
  logic signed [15:0] a0 [2][2];
  logic signed [15:0] b0 [2][2];
  logic signed [33:0] o0 [2][2];
  logic               busy0, done0, ovf0;

  // u1: M=2, K=3, N=1, DATA_W=16
  logic               start1;
  logic signed [15:0] a1 [2][3];
  logic signed [15:0] b1 [3][1];
  logic signed [33:0] o1 [2][1];
  logic               busy1, done1, ovf1;

  // u2: M=2, K=1, N=2, DATA_W=8, OUT_W=16
  logic               start2;
  logic signed [7:0]  a2 [2][1];
  logic signed [7:0]  b2 [1][2];
  logic signed [16:0] o2 [2][2];
  logic               busy2, done2, ovf2;

  // u3: 2x2x2, DATA_W=8, OUT_W=8
  logic               start3;
  logic signed [7:0]  a3 [2][2];
  logic signed [7:0]  b3 [2][2];
  logic signed [17:0] o3 [2][2];
  logic               busy3, done3, ovf3;

  mat_mult_seq #(.M(2), .K(2), .N(2), .DATA_W(16)) u0 (
    .clk(clk), .reset(rst), .start(start0), .mat_a(a0), .mat_b(b0),
    .busy(busy0), .done(done0), .mat_out(o0), .overflow(ovf0));

  mat_mult_seq #(.M(2), .K(3), .N(1), .DATA_W(16)) u1 (
    .clk(clk), .reset(rst), .start(start1), .mat_a(a1), .mat_b(b1),
    .busy(busy1), .done(done1), .mat_out(o1), .overflow(ovf1));

  mat_mult_seq #(.M(2), .K(1), .N(2), .DATA_W(8), .OUT_W(16)) u2 (
    .clk(clk), .reset(rst), .start(start2), .mat_a(a2), .mat_b(b2),
    .busy(busy2), .done(done2), .mat_out(o2), .overflow(ovf2));

  mat_mult_seq #(.M(2), .K(2), .N(2), .DATA_W(8), .OUT_W(8)) u3 (
    .clk(clk), .reset(rst), .start(start3), .mat_a(a3), .mat_b(b3),
    .busy(busy3), .done(done3), .mat_out(o3), .overflow(ovf3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_u0(input int a00, input int a01, input int a10, input int a11);
    a0[0][0] = 16'(a00); a0[0][1] = 16'(a01);
    a0[1][0] = 16'(a10); a0[1][1] = 16'(a11);
    b0[0][0] = 16'sd5; b0[0][1] = 16'sd6;
    b0[1][0] = 16'sd7; b0[1][1] = 16'sd8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf0); end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (o0[i][j] !== 34'sd0) begin
          errors++; $display("FAIL reset_out[%0d][%0d] got %0d want 0", i, j, o0[i][j]);
        end
      end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, bcnt;
    load_u0(1, 2, 3, 4);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    load_u0(9, 9, 9, 9);  // operands must have been latched at accept
    cyc = 0; bcnt = 0;
    while (done0 !== 1'b1 && cyc < 20) begin
      if (busy0 === 1'b1) bcnt++;
      tick(); cyc++;
    end
    checks++; if (cyc != 5) begin errors++; $display("FAIL basic_latency got %0d want 5", cyc); end
    checks++; if (bcnt != 4) begin errors++; $display("FAIL basic_busy_cycles got %0d want 4", bcnt); end
    checks++; if (o0[0][0] !== 19) begin errors++; $display("FAIL basic_out00 got %0d want 19", o0[0][0]); end
    checks++; if (o0[0][1] !== 22) begin errors++; $display("FAIL basic_out01 got %0d want 22", o0[0][1]); end
    checks++; if (o0[1][0] !== 43) begin errors++; $display("FAIL basic_out10 got %0d want 43", o0[1][0]); end
    checks++; if (o0[1][1] !== 50) begin errors++; $display("FAIL basic_out11 got %0d want 50", o0[1][1]); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", ovf0); end
    tick();
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done0); end
    checks++; if (o0[1][1] !== 50) begin errors++; $display("FAIL basic_hold got %0d want 50", o0[1][1]); end
  endtask

  task automatic test_rect();
    int cyc;
    a1[0][0] = 16'sd1;  a1[0][1] = -16'sd2; a1[0][2] = 16'sd3;
    a1[1][0] = -16'sd4; a1[1][1] = 16'sd5;  a1[1][2] = -16'sd6;
    b1[0][0] = 16'sd7;  b1[1][0] = 16'sd8;  b1[2][0] = 16'sd9;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++; if (cyc != 4) begin errors++; $display("FAIL rect_latency got %0d want 4", cyc); end
    checks++; if (o1[0][0] !== 18) begin errors++; $display("FAIL rect_out0 got %0d want 18", o1[0][0]); end
    checks++; if (o1[1][0] !== -42) begin errors++; $display("FAIL rect_out1 got %0d want -42", o1[1][0]); end
  endtask

  task automatic test_k1();
    int cyc;
    a2[0][0] = -8'sd128; a2[1][0] = 8'sd1;
    b2[0][0] = -8'sd128; b2[0][1] = 8'sd2;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++; if (cyc != 3) begin errors++; $display("FAIL k1_latency got %0d want 3", cyc); end
    checks++; if (o2[0][0] !== 16384) begin errors++; $display("FAIL k1_out00 got %0d want 16384", o2[0][0]); end
    checks++; if (o2[0][1] !== -256) begin errors++; $display("FAIL k1_out01 got %0d want -256", o2[0][1]); end
    checks++; if (o2[1][0] !== -128) begin errors++; $display("FAIL k1_out10 got %0d want -128", o2[1][0]); end
    checks++; if (o2[1][1] !== 2) begin errors++; $display("FAIL k1_out11 got %0d want 2", o2[1][1]); end
  endtask

  task automatic test_sat();
    int cyc, exp_v;
    logic exp_o;
`ifdef MAT_MULT_SAT_EN
    exp_v = 127;   exp_o = 1'b1;
`else
    exp_v = 32258; exp_o = 1'b0;
`endif
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        a3[i][j] = 8'sd127; b3[i][j] = 8'sd127;
      end
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 0;
    while (done3 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++; if (cyc != 5) begin errors++; $display("FAIL sat_latency got %0d want 5", cyc); end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (o3[i][j] !== exp_v) begin
          errors++; $display("FAIL sat_out[%0d][%0d] got %0d want %0d", i, j, o3[i][j], exp_v);
        end
      end
    checks++; if (ovf3 !== exp_o) begin errors++; $display("FAIL sat_ovf got %b want %b", ovf3, exp_o); end
  endtask

  task automatic test_back_to_back();
    int ndone, first_t, second_t, cyc;
    load_u0(1, 2, 3, 4);
    start0 = 1'b1;
    tick();
    load_u0(2, 0, 0, 2);
    ndone = 0; first_t = -1; second_t = -1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (done0 === 1'b1) begin
        ndone++;
        if (first_t < 0) begin
          first_t = t;
          checks++; if (o0[0][0] !== 19) begin errors++; $display("FAIL b2b_job1_out00 got %0d want 19", o0[0][0]); end
        end else begin
          second_t = t;
          checks++; if (o0[0][0] !== 10) begin errors++; $display("FAIL b2b_job2_out00 got %0d want 10", o0[0][0]); end
          checks++; if (o0[1][1] !== 16) begin errors++; $display("FAIL b2b_job2_out11 got %0d want 16", o0[1][1]); end
        end
      end
    end
    checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
    checks++; if (second_t - first_t != 6) begin errors++; $display("FAIL b2b_period got %0d want 6", second_t - first_t); end
    start0 = 1'b0;
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++; if (cyc >= 20) begin errors++; $display("FAIL b2b_drain got timeout want done"); end
    tick();
  endtask

  task automatic test_ignore_start();
    int ndone;
    load_u0(1, 2, 3, 4);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    ndone = 0;
    for (int t = 1; t <= 14; t++) begin
      start0 = (t == 2 || t == 3 || t == 4) ? 1'b1 : 1'b0;  // pulses only while CALC/DONE
      tick();
      if (done0 === 1'b1) ndone++;
    end
    start0 = 1'b0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
  endtask

  task automatic test_midreset();
    int ndone, cyc;
    load_u0(2, 0, 0, 2);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy0); end
    checks++; if (o0[0][0] !== 34'sd0) begin errors++; $display("FAIL midrst_out00 got %0d want 0", o0[0][0]); end
    ndone = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done0 === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_done_count got %0d want 0", ndone); end
    // reset and start in the same cycle: start is dropped
    rst = 1'b1; start0 = 1'b1;
    tick();
    rst = 1'b0; start0 = 1'b0;
    tick();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b want 0", busy0); end
    load_u0(1, 2, 3, 4);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++; if (cyc != 5) begin errors++; $display("FAIL midrst_recover_latency got %0d want 5", cyc); end
    checks++; if (o0[1][0] !== 43) begin errors++; $display("FAIL midrst_recover_out10 got %0d want 43", o0[1][0]); end
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    load_u0(0, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) a1[i][j] = '0;
    for (int i = 0; i < 3; i++) b1[i][0] = '0;
    for (int i = 0; i < 2; i++) begin
      a2[i][0] = '0; b2[0][i] = '0;
      for (int j = 0; j < 2; j++) begin a3[i][j] = '0; b3[i][j] = '0; end
    end
    test_reset();
    test_basic();
    test_rect();
    test_k1();
    test_sat();
    test_back_to_back();
    test_ignore_start();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
